// File: rtl/mem_resp_stage.sv
// MEM stage for the five-stage MIPS core: holds loads until data_ok, buffers under WB stall,
// aligns load data and drops stale beats after a flush. `define MS_UNALIGNED_LOAD_EN enables LWL/LWR merging.
module mem_resp_stage #(
   parameter int SIDE_W          = 64,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ws_allowin,
   output logic              ms_allowin,
   input  logic              es_to_ms_valid,
   input  logic [31:0]       es_pc,
   input  logic [31:0]       es_alu_result,
   input  logic [31:0]       es_rt_value,
   input  logic [2:0]        es_load_op,
   input  logic              es_res_from_mem,
   input  logic              es_mem_req,
   input  logic              es_gr_we,
   input  logic [4:0]        es_dest,
   input  logic              es_ex,
   input  logic [SIDE_W-1:0] es_side,
   input  logic              es_req_killed,
   input  logic              data_sram_data_ok,
   input  logic [31:0]       data_sram_rdata,
   input  logic              ex_flush,
   output logic              ms_to_ws_valid,
   output logic [31:0]       ms_pc,
   output logic [31:0]       ms_final_result,
   output logic              ms_gr_we,
   output logic [4:0]        ms_dest,
   output logic [SIDE_W-1:0] ms_side,
   output logic              ms_fw_valid,
   output logic              ms_fw_stall,
   output logic              ms_ex
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic          ms_valid;
   logic          resp_got;
   logic [CW-1:0] discard_cnt;

   logic          mem_req_r;
   logic          res_from_mem_r;
   logic          gr_we_r;
   logic          ex_r;
   logic [31:0]   pc_r;
   logic [31:0]   alu_result_r;
   logic [31:0]   rt_value_r;
   logic [2:0]    load_op_r;
   logic [4:0]    dest_r;
   logic [SIDE_W-1:0] side_r;
   logic [31:0]   rdata_buf;

   logic ms_ready_go;
   logic capture;
   logic leave;
   logic drop_beat;
   logic own_beat;
   logic flush_orphan;

   assign ms_ready_go    = !mem_req_r || resp_got || (data_sram_data_ok && discard_cnt == '0);
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign capture        = es_to_ms_valid && ms_allowin;
   assign leave          = ms_to_ws_valid && ws_allowin;

   // Beats are strictly in order: stale ones owed to killed instructions come first.
   assign drop_beat    = data_sram_data_ok && (discard_cnt != '0);
   assign own_beat     = data_sram_data_ok && (discard_cnt == '0) && ms_valid && mem_req_r && !resp_got;
   assign flush_orphan = ex_flush && ms_valid && mem_req_r && !resp_got && !own_beat;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid       <= 1'b0;
         resp_got       <= 1'b0;
         discard_cnt    <= '0;
         mem_req_r      <= 1'b0;
         res_from_mem_r <= 1'b0;
         gr_we_r        <= 1'b0;
         ex_r           <= 1'b0;
      end else begin
         if (ex_flush)
            ms_valid <= 1'b0;
         else if (ms_allowin)
            ms_valid <= es_to_ms_valid;

         if (capture) begin
            resp_got       <= 1'b0;
            mem_req_r      <= es_mem_req;
            res_from_mem_r <= es_res_from_mem;
            gr_we_r        <= es_gr_we;
            ex_r           <= es_ex;
         end else if (own_beat && !leave && !ex_flush) begin
            resp_got <= 1'b1;
         end

         discard_cnt <= discard_cnt + CW'(flush_orphan) + CW'(es_req_killed) - CW'(drop_beat);
      end
   end

   // Payload registers carry no reset; they are qualified by ms_valid everywhere.
   always_ff @(posedge clk) begin
      if (capture) begin
         pc_r         <= es_pc;
         alu_result_r <= es_alu_result;
         rt_value_r   <= es_rt_value;
         load_op_r    <= es_load_op;
         dest_r       <= es_dest;
         side_r       <= es_side;
      end
      if (own_beat && !leave)
         rdata_buf <= data_sram_rdata;
   end

   logic [31:0] ld_data;
   logic [31:0] load_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [1:0]  addr_lo;

   assign addr_lo = alu_result_r[1:0];
   assign ld_data = resp_got ? rdata_buf : data_sram_rdata;

   always_comb begin
      byte_sel = ld_data[7:0];
      case (addr_lo)
         2'd0: byte_sel = ld_data[7:0];
         2'd1: byte_sel = ld_data[15:8];
         2'd2: byte_sel = ld_data[23:16];
         2'd3: byte_sel = ld_data[31:24];
         default: byte_sel = ld_data[7:0];
      endcase
      half_sel = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
   end

`ifdef MS_UNALIGNED_LOAD_EN
   logic [31:0] lwl_val;
   logic [31:0] lwr_val;

   always_comb begin
      lwl_val = ld_data;
      lwr_val = ld_data;
      case (addr_lo)
         2'd0: begin
            lwl_val = {ld_data[7:0],  rt_value_r[23:0]};
            lwr_val = ld_data;
         end
         2'd1: begin
            lwl_val = {ld_data[15:0], rt_value_r[15:0]};
            lwr_val = {rt_value_r[31:24], ld_data[31:8]};
         end
         2'd2: begin
            lwl_val = {ld_data[23:0], rt_value_r[7:0]};
            lwr_val = {rt_value_r[31:16], ld_data[31:16]};
         end
         2'd3: begin
            lwl_val = ld_data;
            lwr_val = {rt_value_r[31:8], ld_data[31:24]};
         end
         default: begin
            lwl_val = ld_data;
            lwr_val = ld_data;
         end
      endcase
   end
`else
   logic unused_rt;
   assign unused_rt = ^rt_value_r;
`endif

   always_comb begin
      load_val = ld_data;
      case (load_op_r)
         3'd1: load_val = {{24{byte_sel[7]}}, byte_sel};
         3'd2: load_val = {24'd0, byte_sel};
         3'd3: load_val = {{16{half_sel[15]}}, half_sel};
         3'd4: load_val = {16'd0, half_sel};
`ifdef MS_UNALIGNED_LOAD_EN
         3'd5: load_val = lwl_val;
         3'd6: load_val = lwr_val;
`endif
         default: load_val = ld_data;
      endcase
   end

   assign ms_final_result = res_from_mem_r ? load_val : alu_result_r;
   assign ms_pc           = pc_r;
   assign ms_gr_we        = gr_we_r;
   assign ms_dest         = dest_r;
   assign ms_side         = side_r;
   assign ms_fw_valid     = ms_valid && gr_we_r;
   assign ms_fw_stall     = ms_valid && res_from_mem_r && !ms_ready_go;
   assign ms_ex           = ms_valid && ex_r;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Scoreboard bench for mem_resp_stage: each retired instruction is popped against the expected queue.
module tb_mem_resp_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_pc, es_alu_result, es_rt_value;
   logic [2:0]  es_load_op;
   logic        es_res_from_mem, es_mem_req, es_gr_we, es_ex, es_req_killed;
   logic [4:0]  es_dest;
   logic [63:0] es_side;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ex_flush;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc, ms_final_result;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [63:0] ms_side;
   logic        ms_fw_valid, ms_fw_stall, ms_ex;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   mem_resp_stage #(.SIDE_W(64), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_alu_result(es_alu_result),
      .es_rt_value(es_rt_value), .es_load_op(es_load_op), .es_res_from_mem(es_res_from_mem),
      .es_mem_req(es_mem_req), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_ex(es_ex),
      .es_side(es_side), .es_req_killed(es_req_killed), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata), .ex_flush(ex_flush), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ms_side(ms_side), .ms_fw_valid(ms_fw_valid), .ms_fw_stall(ms_fw_stall), .ms_ex(ms_ex)
   );

   always #5 clk = ~clk;

   // Retirement monitor: inputs change at negedge, so negedge+4 is settled and clear of posedge.
   always @(negedge clk) begin
      #4;
      if (resetn && ms_to_ws_valid && ws_allowin && !ex_flush) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected pc=%h result=%h, no result expected", ms_pc, ms_final_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ms_pc !== e.pc || ms_final_result !== e.res) begin
               fails++;
               $display("FAIL sb_retire got pc=%h res=%h, want pc=%h res=%h",
                        ms_pc, ms_final_result, e.pc, e.res);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (resetn)
         assert (int'(dut.discard_cnt) <= 2)
         else $error("FAIL discard_cnt_overflow got %0d, max 2", dut.discard_cnt);
   end

   task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [2:0] op, input logic rfm, input logic mreq);
      es_to_ms_valid  = 1'b1;
      es_pc           = pc;
      es_alu_result   = alu;
      es_rt_value     = rt;
      es_load_op      = op;
      es_res_from_mem = rfm;
      es_mem_req      = mreq;
      es_gr_we        = 1'b1;
      es_dest         = pc[6:2];
      es_ex           = 1'b0;
      es_side         = {pc, alu};
   endtask

   task automatic idle_es();
      es_to_ms_valid = 1'b0;
      es_ex          = 1'b0;
   endtask

   task automatic beat(input logic ok, input logic [31:0] d);
      data_sram_data_ok = ok;
      data_sram_rdata   = d;
   endtask

   task automatic test_reset();
      @(negedge clk); #2;
      tests += 5;
      if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL rst_to_ws_valid got %b want 0", ms_to_ws_valid); end
      if (ms_allowin !== 1'b1)     begin fails++; $display("FAIL rst_allowin got %b want 1", ms_allowin); end
      if (ms_ex !== 1'b0)          begin fails++; $display("FAIL rst_ex got %b want 0", ms_ex); end
      if (ms_fw_valid !== 1'b0)    begin fails++; $display("FAIL rst_fw_valid got %b want 0", ms_fw_valid); end
      if (ms_fw_stall !== 1'b0)    begin fails++; $display("FAIL rst_fw_stall got %b want 0", ms_fw_stall); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_addu();
      @(negedge clk);
      send(32'h100, 32'h0000_1234, 32'h0, 3'd0, 1'b0, 1'b0);
      sb.push_back('{pc: 32'h100, res: 32'h0000_1234});
      @(negedge clk);
      idle_es(); #2;
      tests += 3;
      if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL addu_valid got %b want 1", ms_to_ws_valid); end
      if (ms_fw_valid !== 1'b1)    begin fails++; $display("FAIL addu_fw_valid got %b want 1", ms_fw_valid); end
      if (ms_dest !== 5'd0)        begin fails++; $display("FAIL addu_dest got %0d want 0", ms_dest); end
      @(negedge clk); #2;
      tests++;
      if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL addu_gone got %b want 0", ms_to_ws_valid); end
   endtask

   task automatic test_lb_wait();
      @(negedge clk);
      send(32'h200, 32'h0000_1003, 32'h0, 3'd1, 1'b1, 1'b1);
      sb.push_back('{pc: 32'h200, res: 32'hFFFF_FF80});
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         idle_es(); #2;
         tests += 2;
         if (ms_fw_stall !== 1'b1)    begin fails++; $display("FAIL lb_stall%0d got %b want 1", c, ms_fw_stall); end
         if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL lb_early%0d got %b want 0", c, ms_to_ws_valid); end
      end
      @(negedge clk);
      beat(1'b1, 32'h80FF_0000); #2;
      tests += 3;
      if (ms_to_ws_valid !== 1'b1)        begin fails++; $display("FAIL lb_valid got %b want 1", ms_to_ws_valid); end
      if (ms_fw_stall !== 1'b0)           begin fails++; $display("FAIL lb_stall_clr got %b want 0", ms_fw_stall); end
      if (ms_final_result !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_result got %h want ffffff80", ms_final_result); end
      @(negedge clk);
      beat(1'b0, 32'h0);
   endtask

   task automatic test_lhu_stall();
      @(negedge clk);
      send(32'h300, 32'h0000_2002, 32'h0, 3'd4, 1'b1, 1'b1);
      sb.push_back('{pc: 32'h300, res: 32'h0000_8001});
      @(negedge clk);
      idle_es();
      ws_allowin = 1'b0;
      beat(1'b1, 32'h8001_1234); #2;
      tests += 2;
      if (ms_allowin !== 1'b0)     begin fails++; $display("FAIL lhu_allowin0 got %b want 0", ms_allowin); end
      if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL lhu_valid0 got %b want 1", ms_to_ws_valid); end
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         beat(1'b0, 32'hFFFF_FFFF); #2;
         tests += 2;
         if (ms_allowin !== 1'b0) begin fails++; $display("FAIL lhu_allowin%0d got %b want 0", c, ms_allowin); end
         if (ms_final_result !== 32'h0000_8001) begin fails++; $display("FAIL lhu_buf%0d got %h want 00008001", c, ms_final_result); end
      end
      @(negedge clk);
      ws_allowin = 1'b1; #2;
      tests++;
      if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL lhu_release got %b want 1", ms_to_ws_valid); end
      @(negedge clk); #2;
      tests++;
      if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL lhu_gone got %b want 0", ms_to_ws_valid); end
   endtask

   task automatic test_flush_discard();
      @(negedge clk);
      send(32'h400, 32'h0000_3000, 32'h0, 3'd0, 1'b1, 1'b1);
      @(negedge clk);
      idle_es();
      ex_flush = 1'b1;
      es_req_killed = 1'b1;
      @(negedge clk);
      ex_flush = 1'b0;
      es_req_killed = 1'b0;
      send(32'h500, 32'h0000_3004, 32'h0, 3'd0, 1'b1, 1'b1);
      sb.push_back('{pc: 32'h500, res: 32'hDEAD_BEEF});
      #2;
      tests += 2;
      if (dut.discard_cnt !== 2'd2) begin fails++; $display("FAIL flush_cnt got %0d want 2", dut.discard_cnt); end
      if (ms_to_ws_valid !== 1'b0)  begin fails++; $display("FAIL flush_valid got %b want 0", ms_to_ws_valid); end
      @(negedge clk);
      idle_es();
      beat(1'b1, 32'h1111_1111); #2;
      tests++;
      if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL drop1_valid got %b want 0", ms_to_ws_valid); end
      @(negedge clk);
      beat(1'b1, 32'h2222_2222); #2;
      tests++;
      if (ms_to_ws_valid !== 1'b0) begin fails++; $display("FAIL drop2_valid got %b want 0", ms_to_ws_valid); end
      @(negedge clk);
      beat(1'b1, 32'hDEAD_BEEF); #2;
      tests++;
      if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL third_valid got %b want 1", ms_to_ws_valid); end
      @(negedge clk);
      beat(1'b0, 32'h0); #2;
      tests += 2;
      if (dut.discard_cnt !== 2'd0) begin fails++; $display("FAIL drain_cnt got %0d want 0", dut.discard_cnt); end
      if (ms_to_ws_valid !== 1'b0)  begin fails++; $display("FAIL drain_valid got %b want 0", ms_to_ws_valid); end
   endtask

   task automatic test_flush_with_beat();
      @(negedge clk);
      send(32'h600, 32'h0000_3008, 32'h0, 3'd0, 1'b1, 1'b1);
      @(negedge clk);
      idle_es();
      ex_flush = 1'b1;
      beat(1'b1, 32'h6666_6666);
      @(negedge clk);
      ex_flush = 1'b0;
      beat(1'b0, 32'h0); #2;
      tests += 2;
      if (dut.discard_cnt !== 2'd0) begin fails++; $display("FAIL coflush_cnt got %0d want 0", dut.discard_cnt); end
      if (ms_to_ws_valid !== 1'b0)  begin fails++; $display("FAIL coflush_valid got %b want 0", ms_to_ws_valid); end
   endtask

   task automatic test_lwl();
      logic [31:0] want;
`ifdef MS_UNALIGNED_LOAD_EN
      want = 32'hCCDD_3344;
`else
      want = 32'hAABB_CCDD;
`endif
      @(negedge clk);
      send(32'h700, 32'h0000_4001, 32'h1122_3344, 3'd5, 1'b1, 1'b1);
      sb.push_back('{pc: 32'h700, res: want});
      @(negedge clk);
      idle_es();
      beat(1'b1, 32'hAABB_CCDD); #2;
      tests++;
      if (ms_final_result !== want) begin fails++; $display("FAIL lwl_result got %h want %h", ms_final_result, want); end
      @(negedge clk);
      beat(1'b0, 32'h0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      send(32'h800, 32'h0000_5000, 32'h0, 3'd0, 1'b1, 1'b1);
      sb.push_back('{pc: 32'h800, res: 32'h1234_5678});
      @(negedge clk);
      send(32'h804, 32'h0000_0055, 32'h0, 3'd0, 1'b0, 1'b0);
      es_ex = 1'b1;
      sb.push_back('{pc: 32'h804, res: 32'h0000_0055});
      beat(1'b1, 32'h1234_5678); #2;
      tests++;
      if (ms_allowin !== 1'b1) begin fails++; $display("FAIL b2b_allowin got %b want 1", ms_allowin); end
      @(negedge clk);
      idle_es();
      beat(1'b0, 32'h0); #2;
      tests += 2;
      if (ms_ex !== 1'b1)          begin fails++; $display("FAIL b2b_ex got %b want 1", ms_ex); end
      if (ms_to_ws_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b want 1", ms_to_ws_valid); end
      @(negedge clk); #2;
      tests++;
      if (ms_ex !== 1'b0) begin fails++; $display("FAIL b2b_ex_clr got %b want 0", ms_ex); end
   endtask

   initial begin
      resetn = 1'b0;
      ws_allowin = 1'b1;
      es_to_ms_valid = 1'b0;
      es_pc = '0; es_alu_result = '0; es_rt_value = '0; es_load_op = '0;
      es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_gr_we = 1'b0; es_dest = '0;
      es_ex = 1'b0; es_side = '0; es_req_killed = 1'b0;
      data_sram_data_ok = 1'b0; data_sram_rdata = '0; ex_flush = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_addu();
      test_lb_wait();
      test_lhu_stall();
      test_flush_discard();
      test_flush_with_beat();
      test_lwl();
      test_back_to_back();
      repeat (2) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover got %0d entries want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_resp_stage.md
# mem_resp_stage

Parametrised memory-access pipeline stage for the five-stage MIPS core, sitting between EX and WB. It handles a data SRAM with a request/response (data_ok) handshake instead of a fixed one-cycle read. The stage holds a load until its response arrives, buffers the response if WB stalls, and aligns/extends load data. It also discards stale responses belonging to instructions killed by an exception flush.

## Interface
Parameters:
- SIDE_W, 64: width of opaque sideband carried EX→WB untouched (cp0 fields, bd, eret, etc.).
- MAX_OUTSTANDING, 2: max responses the discard counter must track; counter width = clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ws_allowin  in  1  WB can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  EX presents an instruction.
- es_pc  in  32  PC.
- es_alu_result  in  32  ALU result / load address.
- es_rt_value  in  32  old rt, for LWL/LWR merge.
- es_load_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved (treated as LW).
- es_res_from_mem  in  1  result comes from memory.
- es_mem_req  in  1  instruction had a data-SRAM request accepted in EX; a data_ok is owed.
- es_gr_we  in  1  writes GPR.
- es_dest  in  5  destination register.
- es_ex  in  1  instruction carries an exception.
- es_side  in  SIDE_W  passthrough sideband.
- es_req_killed  in  1  pulse: the flush this cycle dropped an EX instruction whose request was already accepted.
- data_sram_data_ok  in  1  one in-order response beat.
- data_sram_rdata  in  32  response data, valid with data_ok.
- ex_flush  in  1  exception/eret flush.
- ms_to_ws_valid  out  1  result valid to WB.
- ms_pc, ms_final_result  out  32 each  to WB.
- ms_gr_we, ms_dest, ms_side  out  1/5/SIDE_W  registered copies.
- ms_fw_valid  out  1  ms_valid & ms_gr_we.
- ms_fw_stall  out  1  ms_valid & res_from_mem & !ms_ready_go; ID must stall rather than forward.
- ms_ex  out  1  ms_valid & latched es_ex.

## Operation
- Capture: on es_to_ms_valid & ms_allowin, all es_* fields are latched, ms_valid←1, and resp_got←0. If ms_allowin is set and es_to_ms_valid is 0, ms_valid←0.
- ms_ready_go = !mem_req_r | resp_got | (data_ok & discard_cnt==0).
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
- Response routing, in order, one data_ok per cycle:
  - If discard_cnt>0, the beat is dropped and discard_cnt decrements.
  - Otherwise, if ms_valid & mem_req_r & !resp_got, the beat belongs to this instruction.
  - When the instruction does not leave this cycle, rdata goes into rdata_buf and resp_got←1.
- Result data = resp_got ? rdata_buf : data_sram_rdata, with same-cycle bypass.
- Alignment uses addr[1:0] of alu_result:
  - LB/LBU select byte addr; LB sign-extends, LBU zero-extends.
  - LH/LHU select the upper half if addr[1] is set, else the lower half; LH sign-extends, LHU zero-extends.
  - LW passes the word through.
- ms_final_result = res_from_mem ? aligned load : alu_result.
- Flush:
  - ms_valid←0 on ex_flush, overriding capture.
  - discard_cnt += (ms_valid & mem_req_r & !resp_got & !beat_consumed_this_cycle) + es_req_killed, minus 1 if a data_ok was dropped.
  - All terms are applied in the same cycle.
- discard_cnt never exceeds MAX_OUTSTANDING; overflow is a design error and the bench asserts on it.

## Timing
- Reset (asynchronous, resetn low) values:
  - ms_valid=0, resp_got=0, discard_cnt=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, ms_ex=0, ms_fw_valid=0, ms_fw_stall=0.
  - Data registers are don't-care.
- Reset mid-wait abandons the owed response; the memory side is reset together with the core.
- Latency:
  - Non-memory instructions: 1 cycle in stage.
  - Loads: leave in the data_ok cycle, or later if ws_allowin=0, from the buffer.
- Buffered response survives any number of WB stall cycles; resp_got clears only on a new capture.
- A new instruction may be accepted while discard_cnt>0; its beat arrives after the discarded ones.
- Flush with a simultaneous data_ok owed to this instruction: the beat is dropped and no increment occurs.

## Configuration
- MS_UNALIGNED_LOAD_EN defined:
  - LWL merges per byte: addr 0 → {rdata[7:0], rt[23:0]}, 1 → {rdata[15:0], rt[15:0]}, 2 → {rdata[23:0], rt[7:0]}, 3 → rdata.
  - LWR merges per byte: addr 0 → rdata, 1 → {rt[31:24], rdata[31:8]}, 2 → {rt[31:16], rdata[31:16]}, 3 → {rt[31:8], rdata[31:24]}.
- Undefined: codes 5/6 behave as LW, and es_rt_value is ignored.

## Test plan
- LB, addr 0x...03, data_ok two cycles after capture with rdata 0x80FF_0000 → ms_fw_stall=1 for 2 cycles; result 0xFFFF_FF80, valid in the data_ok cycle.
- LHU, addr 0x...02, data_ok while ws_allowin=0 for 3 cycles with rdata 0x8001_1234 → result 0x0000_8001 after stall; ms_allowin=0 throughout.
- LW waiting, ex_flush and es_req_killed together → discard_cnt=2. The next two data_ok are dropped; the third (0xDEAD_BEEF) completes the following LW.
- ex_flush coincident with data_ok for the pending LW → discard_cnt stays 0; ms_to_ws_valid=0 next cycle.
- With MS_UNALIGNED_LOAD_EN, LWL addr 1, rt 0x1122_3344, rdata 0xAABB_CCDD → 0xCCDD_3344. Without the macro, the same stimulus → 0xAABB_CCDD.
- ADDU (no mem) with ws_allowin=1 → passes in 1 cycle; result = alu_result, and data_ok is not required.
